// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode handshake.
interface fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    output if_instr,
    output if_pc,
    input  id_ready
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register plus a 2-entry {pc, instr} buffer toward decode.
// Optional macro FETCH_PERF_EN enables the fetch_cnt push counter (tied to 0 otherwise).
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] fetch_cnt,
  fetch_if.master     bus
);

  localparam logic [1:0]  FULL_CNT  = 2'(FIFO_DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [31:0] pc_r;
  logic [31:0] pc_mem_r    [2];
  logic [31:0] instr_mem_r [2];
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  count_r;
  logic        pop_s;
  logic        push_s;
  logic        unused_s;

  // Handshake decode: a slot frees up in the same cycle the head is popped.
  always_comb begin
    pop_s  = (count_r != 2'd0) && bus.id_ready;
    push_s = fetch_en && !bus.redirect_valid && ((count_r < FULL_CNT) || pop_s);
  end

  // Head outputs come from buffer registers only, never from imem_instr.
  assign bus.imem_addr = pc_r;
  assign bus.if_valid  = (count_r != 2'd0);
  assign bus.if_instr  = instr_mem_r[rd_ptr_r];
  assign bus.if_pc     = pc_mem_r[rd_ptr_r];
  assign unused_s      = ^bus.redirect_pc[1:0];

  // PC and circular buffer state; redirect flushes and overrides any push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r           <= RESET_PC;
      rd_ptr_r       <= 1'b0;
      wr_ptr_r       <= 1'b0;
      count_r        <= 2'd0;
      pc_mem_r[0]    <= 32'h0000_0000;
      pc_mem_r[1]    <= 32'h0000_0000;
      instr_mem_r[0] <= NOP_INSTR;
      instr_mem_r[1] <= NOP_INSTR;
    end else if (bus.redirect_valid) begin
      pc_r     <= {bus.redirect_pc[31:2], 2'b00};
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        pc_mem_r[wr_ptr_r]    <= pc_r;
        instr_mem_r[wr_ptr_r] <= bus.imem_instr;
        wr_ptr_r              <= ~wr_ptr_r;
        pc_r                  <= pc_r + 32'd4;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] cnt_r;

  // Push counter; survives redirects, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= 32'h0000_0000;
    end else if (push_s) begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  assign fetch_cnt = cnt_r;
`else
  assign fetch_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences, then random traffic vs a queue model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] fetch_cnt;
  int          n_cmp;
  int          n_fail;

  fetch_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_en  (fetch_en),
    .fetch_cnt (fetch_cnt),
    .bus       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory.
  always_comb bus.imem_instr = bus.imem_addr ^ 32'hA5A5_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  typedef struct {
    logic        rst;
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[20];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void model_step(logic rst, logic fe, logic rdy, logic rv, logic [31:0] rpc);
    bit pop, push;
    entry_t e;
    if (!rst) begin
      mq.delete();
      m_pc  = 32'h0000_0000;
      m_cnt = 32'h0000_0000;
    end else begin
      pop  = (mq.size() > 0) && rdy;
      push = fe && !rv && ((mq.size() < 2) || pop);
      if (rv) begin
        mq.delete();
        m_pc = rpc & 32'hFFFF_FFFC;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          e.pc    = m_pc;
          e.instr = m_pc ^ 32'hA5A5_0000;
          mq.push_back(e);
          m_pc  = m_pc + 32'd4;
          m_cnt = m_cnt + 32'd1;
        end
      end
    end
  endfunction

  function automatic void check_model();
    logic [31:0] exp_cnt;
`ifdef FETCH_PERF_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 32'h0000_0000;
`endif
    check("model_valid", {31'd0, bus.if_valid}, {31'd0, mq.size() > 0});
    check("model_addr", bus.imem_addr, m_pc);
    check("model_cnt", fetch_cnt, exp_cnt);
    if (mq.size() > 0) begin
      check("model_pc", bus.if_pc, mq[0].pc);
      check("model_instr", bus.if_instr, mq[0].instr);
    end
  endfunction

  task automatic cycle(input logic rst, input logic fe, input logic rdy,
                       input logic rv, input logic [31:0] rpc);
    rst_n              = rst;
    fetch_en           = fe;
    bus.id_ready       = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    model_step(rst, fe, rdy, rv, rpc);
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n = 1'b0; fetch_en = 1'b0; bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;

    // rst fe rdy rv rpc | valid pc addr
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         32'h4};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h8};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h8};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h8};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h8};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h8};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         32'hC};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         32'h10};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h103,       1'b0, 32'h0,         32'h100};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h100,       32'h104};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h104,       32'h108};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h108};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h108};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h108,       32'h10C};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h108,       32'h110};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'hFFFF_FFFC};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0};
    vecs[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         32'h4};

    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].rst, vecs[i].fe, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      check($sformatf("vec%0d_valid", i), {31'd0, bus.if_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_pc", i), bus.if_pc, vecs[i].e_pc);
        check($sformatf("vec%0d_instr", i), bus.if_instr, vecs[i].e_pc ^ 32'hA5A5_0000);
      end
      if (i == 0 || i == 16) begin
        check($sformatf("vec%0d_cnt", i), fetch_cnt, 32'h0);
      end
      if (i == 0) begin
        check("reset_instr", bus.if_instr, 32'h0000_0013);
        check("reset_pc", bus.if_pc, 32'h0);
      end
    end

    // Ten pushes then a redirect: the counter keeps its value.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_PERF_EN
    check("perf_cnt_10", fetch_cnt, 32'd10);
`else
    check("perf_cnt_off", fetch_cnt, 32'd0);
`endif

    // Random traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 11) == 0),
            $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
